instr_seq_ctrl: RTL and testbench

//  Fetch/issue sequencer for the single-cycle execute unit (GPR/SGPR datapath, 32-bit IR).
//  - Reads instructions from a synchronous block RAM (1-cycle read latency), steps the PC,

---
 rtl/cpu_isa_pkg.sv | 45 ++++
 rtl/instr_seq_ctrl_if.sv | 12 +
 rtl/instr_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_instr_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// ISA definitions shared by the fetch/issue sequencer and the execute datapath.
// Holds opcodes, IR field layout and the sequencer state encoding.
package cpu_isa_pkg;

    typedef enum logic [4:0] {
        OP_MOVSGPR = 5'd0,
        OP_MOV     = 5'd1,
        OP_ADD     = 5'd2,
        OP_SUB     = 5'd3,
        OP_MUL     = 5'd4,
        OP_ROR     = 5'd5,
        OP_RAND    = 5'd6,
        OP_RXOR    = 5'd7,
        OP_RXNOR   = 5'd8,
        OP_RNAND   = 5'd9,
        OP_RNOR    = 5'd10,
        OP_RNOT    = 5'd11,
        OP_HALT    = 5'b11111
    } opcode_t;

    // rsrc2 aliases isrc[15:11] when imm_mode is clear.
    typedef struct packed {
        logic [4:0]  oper_type;
        logic [4:0]  rdst;
        logic [4:0]  rsrc1;
        logic        imm_mode;
        logic [15:0] isrc;
    } ir_fields_t;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 3'd0;
    localparam seq_state_t ST_FETCH = 3'd1;
    localparam seq_state_t ST_LOAD  = 3'd2;
    localparam seq_state_t ST_EXEC  = 3'd3;
    localparam seq_state_t ST_HOLD  = 3'd4;
    localparam seq_state_t ST_DONE  = 3'd5;

    function automatic logic [4:0] get_opcode(input logic [31:0] instr);
        ir_fields_t f;
        f = instr;
        return f.oper_type;
    endfunction

endpackage

// File: rtl/instr_seq_ctrl_if.sv
// Instruction-memory read port between the sequencer (master) and a synchronous RAM (slave).
interface instr_seq_ctrl_if #(
    parameter int ADDR_W  = 11,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rd_en;
    logic [INSTR_W-1:0] imem_dout;

    modport master (output imem_addr, output imem_rd_en, input imem_dout);
    modport slave  (input imem_addr, input imem_rd_en, output imem_dout);
endinterface

// File: rtl/instr_seq_ctrl.sv
// Fetch/issue sequencer: reads the program from a 1-cycle-latency RAM, holds a stable IR
// and pulses exec_en once per instruction until HALT or the last address.
//
//  state | meaning
//  IDLE  | waiting for start after reset
//  FETCH | read issued at fetch address (stalls while pause)
//  LOAD  | RAM data valid; HALT ends the run, else IR captured
//  EXEC  | exec_en strobe, count instruction, arm hold timer
//  HOLD  | IR stable for HOLD_CYCLES, then step PC or finish
//  DONE  | program finished, outputs frozen until start
module instr_seq_ctrl
    import cpu_isa_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int INSTR_W     = 32,
    parameter int HOLD_CYCLES = 2,
    parameter int LAST_ADDR   = 2047
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic                start,
    input  logic                pause,
    instr_seq_ctrl_if.master    imem,
    output logic [INSTR_W-1:0]  ir,
    output logic                exec_en,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                done,
    output logic [15:0]         instr_cnt
);

    localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(LAST_ADDR);

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               is_halt;

    assign is_halt = (get_opcode(imem.imem_dout[INSTR_W-1 -: 32]) == OP_HALT);

    // pc only follows the fetch address once an instruction is actually latched,
    // so a HALT word leaves pc pointing at the last executed instruction.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        tmr_d        = tmr_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_FETCH;
                    fetch_addr_d = '0;
                    pc_d         = '0;
                    cnt_d        = '0;
                end
            end
            ST_FETCH: begin
                if (!pause) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (is_halt) begin
                    state_d = ST_DONE;
                end else begin
                    ir_d    = imem.imem_dout;
                    pc_d    = fetch_addr_q;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                tmr_d   = TMR_LOAD;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (tmr_q == '0) begin
                    if (pc_q == LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        fetch_addr_d = pc_q + ADDR_W'(1);
                        state_d      = ST_FETCH;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= '0;
            pc_q         <= '0;
            ir_q         <= '0;
            tmr_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            tmr_q        <= tmr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign imem.imem_addr  = fetch_addr_q;
    assign imem.imem_rd_en = (state_q == ST_FETCH) && !pause;
    assign ir              = ir_q;
    assign exec_en         = (state_q == ST_EXEC);
    assign pc              = pc_q;
    assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done            = (state_q == ST_DONE);
    assign instr_cnt       = cnt_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed bench for instr_seq_ctrl: default instance plus a HOLD_CYCLES=1 / LAST_ADDR=3 instance,
// each with its own synchronous RAM model; exec_en pulses are checked against a queue of expected issues.
module tb_instr_seq_ctrl;

    typedef struct {
        int          cyc;
        logic [31:0] ir;
        logic [10:0] pc;
    } exp_t;

    localparam logic [31:0] I0   = 32'h0001000F;
    localparam logic [31:0] I1   = 32'h004100FF;
    localparam logic [31:0] HALT = 32'hF8000000;
    localparam logic [31:0] B2   = 32'h08822001;
    localparam logic [31:0] B3   = 32'h10C30005;

    logic clk;
    logic rst_a, start_a, pause_a;
    logic rst_b, start_b, pause_b;
    logic [31:0] a_ir, b_ir;
    logic [10:0] a_pc, b_pc;
    logic        a_exec, b_exec, a_busy, b_busy, a_done, b_done;
    logic [15:0] a_cnt, b_cnt;
    logic        prev_a, prev_b;

    logic [31:0] mema [16];
    logic [31:0] memb [16];

    exp_t qa[$];
    exp_t qb[$];
    int   cyc;
    int   vecs;
    int   errs;

    instr_seq_ctrl_if #(.ADDR_W(11), .INSTR_W(32)) ifa ();
    instr_seq_ctrl_if #(.ADDR_W(11), .INSTR_W(32)) ifb ();

    instr_seq_ctrl #(.ADDR_W(11), .INSTR_W(32), .HOLD_CYCLES(2), .LAST_ADDR(2047)) u_dut_a (
        .clk(clk), .sys_rst(rst_a), .start(start_a), .pause(pause_a), .imem(ifa),
        .ir(a_ir), .exec_en(a_exec), .pc(a_pc), .busy(a_busy), .done(a_done), .instr_cnt(a_cnt)
    );

    instr_seq_ctrl #(.ADDR_W(11), .INSTR_W(32), .HOLD_CYCLES(1), .LAST_ADDR(3)) u_dut_b (
        .clk(clk), .sys_rst(rst_b), .start(start_b), .pause(pause_b), .imem(ifb),
        .ir(b_ir), .exec_en(b_exec), .pc(b_pc), .busy(b_busy), .done(b_done), .instr_cnt(b_cnt)
    );

    always @(posedge clk) begin
        if (ifa.imem_rd_en) ifa.imem_dout <= mema[ifa.imem_addr[3:0]];
        if (ifb.imem_rd_en) ifb.imem_dout <= memb[ifb.imem_addr[3:0]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle, sample just after the edge and score any exec_en pulse.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (a_exec) begin
            chk("a_exec_gap", 32'(prev_a), 32'd0);
            chk("a_exec_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_exec_cycle", 32'(cyc), 32'(e.cyc));
                chk("a_ir", a_ir, e.ir);
                chk("a_pc", 32'(a_pc), 32'(e.pc));
            end
        end else if (qa.size() != 0 && qa[0].cyc == cyc) begin
            e = qa.pop_front();
            chk("a_exec_missing", 32'(a_exec), 32'd1);
        end
        if (b_exec) begin
            chk("b_exec_gap", 32'(prev_b), 32'd0);
            chk("b_exec_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_exec_cycle", 32'(cyc), 32'(e.cyc));
                chk("b_ir", b_ir, e.ir);
                chk("b_pc", 32'(b_pc), 32'(e.pc));
            end
        end else if (qb.size() != 0 && qb[0].cyc == cyc) begin
            e = qb.pop_front();
            chk("b_exec_missing", 32'(b_exec), 32'd1);
        end
        if (ifb.imem_rd_en) chk("b_fetch_within_last", 32'(ifb.imem_addr <= 11'd3), 32'd1);
        prev_a = a_exec;
        prev_b = b_exec;
    endtask

    task automatic push_a(input int c, input logic [31:0] w, input logic [10:0] p);
        exp_t e;
        e.cyc = c; e.ir = w; e.pc = p;
        qa.push_back(e);
    endtask

    task automatic push_b(input int c, input logic [31:0] w, input logic [10:0] p);
        exp_t e;
        e.cyc = c; e.ir = w; e.pc = p;
        qb.push_back(e);
    endtask

    task automatic run_a_to_done(input int bound);
        int n = 0;
        while (!a_done && n < bound) begin
            tick();
            n++;
        end
        chk("a_done_reached", 32'(a_done), 32'd1);
    endtask

    task automatic check_a_final(input string tag);
        chk({tag, "_cnt"}, 32'(a_cnt), 32'd2);
        chk({tag, "_pc"}, 32'(a_pc), 32'd1);
        chk({tag, "_ir"}, a_ir, I1);
        chk({tag, "_busy"}, 32'(a_busy), 32'd0);
        chk({tag, "_rd_en"}, 32'(ifa.imem_rd_en), 32'd0);
    endtask

    initial begin
        int s;
        int n;
        vecs = 0; errs = 0; cyc = 0;
        prev_a = 1'b0; prev_b = 1'b0;
        rst_a = 1'b1; start_a = 1'b0; pause_a = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; pause_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mema[i] = HALT;
            memb[i] = HALT;
        end
        mema[0] = I0; mema[1] = I1; mema[2] = HALT;
        memb[0] = I0; memb[1] = I1; memb[2] = B2; memb[3] = B3;

        tick(); tick();
        chk("rst_ir", a_ir, 32'd0);
        chk("rst_pc", 32'(a_pc), 32'd0);
        chk("rst_exec", 32'(a_exec), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        chk("rst_rd_en", 32'(ifa.imem_rd_en), 32'd0);
        chk("rst_addr", 32'(ifa.imem_addr), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Basic run ending on a HALT word
        s = cyc;
        start_a = 1'b1;
        push_a(s + 3, I0, 11'd0);
        push_a(s + 8, I1, 11'd1);
        tick();
        start_a = 1'b0;
        chk("basic_busy", 32'(a_busy), 32'd1);
        run_a_to_done(40);
        check_a_final("basic");

        // Restart from DONE, with an ignored start pulse mid-run
        s = cyc;
        start_a = 1'b1;
        push_a(s + 3, I0, 11'd0);
        push_a(s + 8, I1, 11'd1);
        tick();
        start_a = 1'b0;
        chk("restart_cnt_clr", 32'(a_cnt), 32'd0);
        chk("restart_pc_clr", 32'(a_pc), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        run_a_to_done(40);
        check_a_final("restart");

        // Pause across HOLD and six FETCH cycles delays the next issue by six
        s = cyc;
        start_a = 1'b1;
        push_a(s + 3, I0, 11'd0);
        push_a(s + 14, I1, 11'd1);
        tick();
        start_a = 1'b0;
        tick(); tick(); tick();
        pause_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("pause_rd_en", 32'(ifa.imem_rd_en), 32'd0);
            chk("pause_ir", a_ir, I0);
            tick();
        end
        pause_a = 1'b0;
        run_a_to_done(40);
        check_a_final("pause");

        // Reset during EXEC
        s = cyc;
        start_a = 1'b1;
        push_a(s + 3, I0, 11'd0);
        tick();
        start_a = 1'b0;
        tick(); tick();
        chk("midrst_in_exec", 32'(a_exec), 32'd1);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("midrst_exec", 32'(a_exec), 32'd0);
        chk("midrst_pc", 32'(a_pc), 32'd0);
        chk("midrst_ir", a_ir, 32'd0);
        chk("midrst_busy", 32'(a_busy), 32'd0);
        chk("midrst_done", 32'(a_done), 32'd0);
        chk("midrst_cnt", 32'(a_cnt), 32'd0);

        // Start and pause together in IDLE: enter FETCH, stall until pause drops
        s = cyc;
        start_a = 1'b1;
        pause_a = 1'b1;
        push_a(s + 6, I0, 11'd0);
        push_a(s + 11, I1, 11'd1);
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_pause_busy", 32'(a_busy), 32'd1);
            chk("idle_pause_rd_en", 32'(ifa.imem_rd_en), 32'd0);
            tick();
        end
        pause_a = 1'b0;
        run_a_to_done(40);
        check_a_final("idle_pause");

        // HOLD_CYCLES=1, LAST_ADDR=3: four back-to-back issues, stop at the last address
        s = cyc;
        start_b = 1'b1;
        push_b(s + 3, I0, 11'd0);
        push_b(s + 7, I1, 11'd1);
        push_b(s + 11, B2, 11'd2);
        push_b(s + 15, B3, 11'd3);
        tick();
        start_b = 1'b0;
        n = 0;
        while (!b_done && n < 40) begin
            tick();
            n++;
        end
        chk("b_done_reached", 32'(b_done), 32'd1);
        chk("b_done_cycle", 32'(cyc), 32'(s + 17));
        chk("b_cnt", 32'(b_cnt), 32'd4);
        chk("b_pc", 32'(b_pc), 32'd3);
        chk("b_ir", b_ir, B3);
        tick(); tick();
        chk("b_done_hold", 32'(b_done), 32'd1);

        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
